// File: rtl/draw_addr_sweep_if.sv
// Beat bus of the draw address sweep: LANES packed lane addresses per beat.
//
// Handshake: the producer raises valid with addr_o/last and holds all three
// stable until the consumer samples ready high on a rising clock edge; the
// beat transfers on that edge (valid && ready) and never otherwise. valid does
// not depend combinationally on ready.
interface draw_addr_sweep_if #(
    parameter int ADDR_W = 14,
    parameter int LANES  = 2
);
    logic [LANES*ADDR_W-1:0] addr_o;
    logic                    valid;
    logic                    ready;
    logic                    last;

    modport master (output addr_o, output valid, output last, input ready);
    modport slave  (input addr_o, input valid, input last, output ready);
endinterface

// File: rtl/draw_addr_sweep.sv
// Framebuffer address-sweep generator for the draw path. Walks a group index
// from a latched first group to a latched last group (inclusive, wrapping
// modulo 2^GW), emitting LANES interleaved lane addresses {grp, lane} per beat.
// Supports one-shot and looping passes, abort via stop, and back-pressure.
module draw_addr_sweep #(
    parameter int ADDR_W = 14,
    parameter int LANES  = 2,
    localparam int LOG2L = $clog2(LANES),
    localparam int GW    = ADDR_W - LOG2L
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active low
    input  logic              start,
    input  logic              stop,
    input  logic              loop_mode,
    input  logic [GW-1:0]     first_grp,
    input  logic [GW-1:0]     last_grp,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_o,    // FSM state for observation
    draw_addr_sweep_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           grp_q, grp_d;
    logic [GW-1:0]           first_q, first_d;
    logic [GW-1:0]           lastg_q, lastg_d;
    logic                    loop_q, loop_d;
    logic [LANES*ADDR_W-1:0] addr_q, addr_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    hs;
    logic [GW-1:0]           grp_inc;

    // Lane k of a beat is the group shifted up by LOG2L with k in the low bits.
    function automatic logic [LANES*ADDR_W-1:0] pack_addr(input logic [GW-1:0] g);
        logic [LANES*ADDR_W-1:0] v;
        v = '0;
        for (int k = 0; k < LANES; k++) begin
            v[k*ADDR_W +: ADDR_W] = (ADDR_W'(g) << LOG2L) | ADDR_W'(k);
        end
        return v;
    endfunction

    assign hs      = valid_q && bus.ready;
    assign grp_inc = grp_q + GW'(1);

    // Next-state and next-output logic; all outputs come straight from flops.
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        first_d = first_q;
        lastg_d = lastg_q;
        loop_d  = loop_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    grp_d   = first_grp;
                    first_d = first_grp;
                    lastg_d = last_grp;
                    loop_d  = loop_mode;
                    addr_d  = pack_addr(first_grp);
                    valid_d = 1'b1;
                    last_d  = (first_grp == last_grp);
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                // stop has priority; a beat handshaken in the same cycle is
                // treated as consumed, but the group does not advance.
                if (stop) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (hs) begin
                    if (last_q) begin
                        done_d = 1'b1;
                        if (loop_q) begin
                            // Restart the range with no bubble on valid.
                            grp_d  = first_q;
                            addr_d = pack_addr(first_q);
                            last_d = (first_q == lastg_q);
                        end else begin
                            state_d = S_DONE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        grp_d  = grp_inc;
                        addr_d = pack_addr(grp_inc);
                        last_d = (grp_inc == lastg_q);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grp_q   <= '0;
            first_q <= '0;
            lastg_q <= '0;
            loop_q  <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            first_q <= first_d;
            lastg_q <= lastg_d;
            loop_q  <= loop_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.addr_o = addr_q;
    assign bus.valid  = valid_q;
    assign bus.last   = last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_draw_addr_sweep.sv
// Bench for draw_addr_sweep: a LANES=2 instance for the main sweeps and a
// LANES=4 instance for the wrap-around range.
module tb_draw_addr_sweep;

    localparam int GWA = 13;
    localparam int GWB = 12;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- DUT A (LANES=2) ----------------
    logic           start_a, stop_a, loop_a, busy_a, done_a;
    logic [GWA-1:0] first_a, last_a;
    logic [1:0]     st_a;
    draw_addr_sweep_if #(.ADDR_W(14), .LANES(2)) bus_a ();

    draw_addr_sweep #(.ADDR_W(14), .LANES(2)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .stop(stop_a),
        .loop_mode(loop_a), .first_grp(first_a), .last_grp(last_a),
        .busy(busy_a), .done(done_a), .state_o(st_a), .bus(bus_a)
    );

    // ---------------- DUT B (LANES=4) ----------------
    logic           start_b, stop_b, loop_b, busy_b, done_b;
    logic [GWB-1:0] first_b, last_b;
    logic [1:0]     st_b;
    draw_addr_sweep_if #(.ADDR_W(14), .LANES(4)) bus_b ();

    draw_addr_sweep #(.ADDR_W(14), .LANES(4)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stop(stop_b),
        .loop_mode(loop_b), .first_grp(first_b), .last_grp(last_b),
        .busy(busy_b), .done(done_b), .state_o(st_b), .bus(bus_b)
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference lane packing, written out lane by lane.
    function automatic logic [27:0] exp_addr_a(input logic [GWA-1:0] g);
        return {g, 1'b1, g, 1'b0};
    endfunction

    function automatic logic [55:0] exp_addr_b(input logic [GWB-1:0] g);
        return {g, 2'd3, g, 2'd2, g, 2'd1, g, 2'd0};
    endfunction

    // ---------------- scoreboards: {last_flag, grp} ----------------
    logic [GWA:0] exp_q_a[$];
    logic [GWB:0] exp_q_b[$];

    task automatic push_pass_a(input logic [GWA-1:0] f, input logic [GWA-1:0] l);
        logic [GWA-1:0] g;
        g = f;
        for (int n = 0; n < 9000; n++) begin
            exp_q_a.push_back({(g == l), g});
            if (g == l) break;
            g = g + 13'd1;
        end
    endtask

    task automatic push_pass_b(input logic [GWB-1:0] f, input logic [GWB-1:0] l);
        logic [GWB-1:0] g;
        g = f;
        for (int n = 0; n < 5000; n++) begin
            exp_q_b.push_back({(g == l), g});
            if (g == l) break;
            g = g + 12'd1;
        end
    endtask

    // Monitor A: compares accepted beats and checks hold under back-pressure.
    int           beats_a = 0;
    int           dones_a = 0;
    logic         hold_a  = 1'b0;
    logic [27:0]  prev_addr_a;
    logic         prev_last_a;
    logic [GWA:0] e_a;
    always @(negedge clk) begin
        if (reset) begin
            if (hold_a) begin
                chk("hold_addr", bus_a.addr_o, prev_addr_a);
                chk("hold_last", bus_a.last, prev_last_a);
            end
            if (done_a) dones_a++;
            if (bus_a.valid && bus_a.ready) begin
                beats_a++;
                if (exp_q_a.size() == 0) begin
                    chk("a_unexpected_beat", exp_q_a.size(), 1);
                end else begin
                    e_a = exp_q_a.pop_front();
                    chk("a_addr", bus_a.addr_o, exp_addr_a(e_a[GWA-1:0]));
                    chk("a_last", bus_a.last, e_a[GWA]);
                end
            end
            hold_a      = bus_a.valid && !bus_a.ready;
            prev_addr_a = bus_a.addr_o;
            prev_last_a = bus_a.last;
        end else begin
            hold_a = 1'b0;
        end
    end

    // Monitor B.
    int           beats_b = 0;
    int           dones_b = 0;
    logic [GWB:0] e_b;
    always @(negedge clk) begin
        if (reset) begin
            if (done_b) dones_b++;
            if (bus_b.valid && bus_b.ready) begin
                beats_b++;
                if (exp_q_b.size() == 0) begin
                    chk("b_unexpected_beat", exp_q_b.size(), 1);
                end else begin
                    e_b = exp_q_b.pop_front();
                    chk("b_addr", bus_b.addr_o, exp_addr_b(e_b[GWB-1:0]));
                    chk("b_last", bus_b.last, e_b[GWB]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a_pass(input logic [GWA-1:0] f, input logic [GWA-1:0] l, input logic lp);
        first_a = f;
        last_a  = l;
        loop_a  = lp;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        // Inputs are free to change once latched.
        first_a = 13'($urandom);
        last_a  = 13'($urandom);
        loop_a  = ~lp;
    endtask

    task automatic drain_a(input int budget, input logic rand_rdy);
        int n;
        n = 0;
        while (exp_q_a.size() != 0 && n < budget) begin
            if (rand_rdy) bus_a.ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("a_drain_timeout", exp_q_a.size(), 0);
        bus_a.ready = 1'b1;
    endtask

    task automatic check_done_a(input string tag);
        chk({tag, "_done"}, done_a, 1);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_valid"}, bus_a.valid, 0);
        step();
        chk({tag, "_done_clr"}, done_a, 0);
        chk({tag, "_idle"}, st_a, 2'd0);
    endtask

    // ---------------- stimulus ----------------
    int b0, d0, n;

    initial begin
        start_a = 0; stop_a = 0; loop_a = 0; first_a = '0; last_a = '0;
        start_b = 0; stop_b = 0; loop_b = 0; first_b = '0; last_b = '0;
        bus_a.ready = 1'b1;
        bus_b.ready = 1'b1;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_valid", bus_a.valid, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_last", bus_a.last, 0);
        chk("rst_addr", bus_a.addr_o, 0);
        chk("rst_state", st_a, 0);
        chk("rst_addr_b", bus_b.addr_o, 0);
        step();
        step();
        reset = 1'b1;
        step();

        // One-shot, full ready.
        push_pass_a(13'd5632, 13'd5760);
        b0 = beats_a; d0 = dones_a;
        start_a_pass(13'd5632, 13'd5760, 1'b0);
        chk("t1_busy", busy_a, 1);
        drain_a(1000, 1'b0);
        check_done_a("t1");
        chk("t1_beats", beats_a - b0, 129);
        chk("t1_done_count", dones_a - d0, 1);

        // Same range under random back-pressure.
        push_pass_a(13'd5632, 13'd5760);
        b0 = beats_a; d0 = dones_a;
        start_a_pass(13'd5632, 13'd5760, 1'b0);
        drain_a(4000, 1'b1);
        check_done_a("t2");
        chk("t2_beats", beats_a - b0, 129);
        chk("t2_done_count", dones_a - d0, 1);

        // Wrap-around range on the four-lane instance.
        push_pass_b(12'd4094, 12'd1);
        b0 = beats_b;
        first_b = 12'd4094; last_b = 12'd1; loop_b = 1'b0; start_b = 1'b1;
        step();
        start_b = 1'b0;
        n = 0;
        while (exp_q_b.size() != 0 && n < 100) begin step(); n++; end
        chk("t3_drain_timeout", exp_q_b.size(), 0);
        chk("t3_done", done_b, 1);
        chk("t3_valid", bus_b.valid, 0);
        chk("t3_beats", beats_b - b0, 4);
        step();

        // Looping single-group range, then stop.
        for (int i = 0; i < 6; i++) exp_q_a.push_back({1'b1, 13'd7});
        d0 = dones_a;
        start_a_pass(13'd7, 13'd7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_valid", bus_a.valid, 1);
            chk("t4_last", bus_a.last, 1);
            step();
        end
        stop_a = 1'b1;
        step();
        stop_a = 1'b0;
        chk("t4_stop_valid", bus_a.valid, 0);
        chk("t4_stop_busy", busy_a, 0);
        chk("t4_stop_done", done_a, 0);
        chk("t4_stop_state", st_a, 0);
        chk("t4_done_count", dones_a - d0, 5);
        chk("t4_queue", exp_q_a.size(), 0);
        step();
        chk("t4_no_late_done", done_a, 0);

        // start during RUN and during DONE is ignored.
        push_pass_a(13'd100, 13'd103);
        start_a_pass(13'd100, 13'd103, 1'b0);
        step();
        first_a = 13'd50; last_a = 13'd60; start_a = 1'b1;
        step();
        start_a = 1'b0;
        drain_a(50, 1'b0);
        chk("t5_done", done_a, 1);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("t5_done_start_state", st_a, 0);
        chk("t5_done_start_valid", bus_a.valid, 0);
        step();
        chk("t5_still_idle", st_a, 0);
        chk("t5_still_invalid", bus_a.valid, 0);

        // stop together with a handshake: beat consumed, group holds.
        for (int g = 200; g < 203; g++) exp_q_a.push_back({1'b0, 13'(g)});
        d0 = dones_a;
        start_a_pass(13'd200, 13'd210, 1'b0);
        step();
        step();
        stop_a = 1'b1;
        step();
        stop_a = 1'b0;
        chk("t6_state", st_a, 0);
        chk("t6_valid", bus_a.valid, 0);
        chk("t6_busy", busy_a, 0);
        chk("t6_done", dones_a - d0, 0);
        chk("t6_addr_hold", bus_a.addr_o, exp_addr_a(13'd202));
        chk("t6_queue", exp_q_a.size(), 0);
        step();

        // Asynchronous reset in the middle of a sweep, then restart.
        push_pass_a(13'd5632, 13'd5760);
        b0 = beats_a;
        start_a_pass(13'd5632, 13'd5760, 1'b0);
        n = 0;
        while (beats_a - b0 < 50 && n < 500) begin step(); n++; end
        chk("t7_reach_50", beats_a - b0, 50);
        #2 reset = 1'b0;
        #1;
        chk("t7_rst_valid", bus_a.valid, 0);
        chk("t7_rst_busy", busy_a, 0);
        chk("t7_rst_last", bus_a.last, 0);
        chk("t7_rst_addr", bus_a.addr_o, 0);
        chk("t7_rst_state", st_a, 0);
        exp_q_a.delete();
        step();
        step();
        reset = 1'b1;
        step();
        push_pass_a(13'd5632, 13'd5640);
        b0 = beats_a;
        start_a_pass(13'd5632, 13'd5640, 1'b0);
        drain_a(100, 1'b0);
        check_done_a("t7");
        chk("t7_beats", beats_a - b0, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
